// File: rtl/bp_pht_scheduler_pkg.sv
// Shared types for the PHT scheduler: 2-bit counter encodings, FSM states and
// the saturating counter update.
package bp_pht_scheduler_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b11;
    localparam logic [1:0] CNT_ST  = 2'b10;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        UPD_RD = 2'd2,
        UPD_WR = 2'd3
    } state_t;

    // Gray-ordered counter: SNT <-> WNT <-> WT <-> ST, saturating at both ends.
    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        case (cnt)
            CNT_SNT: res = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: res = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  res = taken ? CNT_ST  : CNT_WNT;
            default: res = taken ? CNT_ST  : CNT_WT;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bp_pht_scheduler_if.sv
// Lookup, response and update channels between the predictor logic and the
// PHT scheduler.
interface bp_pht_scheduler_if #(
    parameter int IDX_W = 6
);
    // Handshake: a request transfers in a cycle where valid and ready are both 1.
    // ready is combinational and never waits for valid to fall; a request seen
    // with ready=0 is not held by the scheduler (lookups retry, updates drop).
    logic             lk_valid;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_ready;
    logic             rsp_valid;
    logic             rsp_taken;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_ready;
    logic             upd_drop;

    modport slave (
        input  lk_valid, lk_idx, upd_valid, upd_idx, upd_taken,
        output lk_ready, rsp_valid, rsp_taken, upd_ready, upd_drop
    );

    modport master (
        output lk_valid, lk_idx, upd_valid, upd_idx, upd_taken,
        input  lk_ready, rsp_valid, rsp_taken, upd_ready, upd_drop
    );
endinterface

// File: rtl/bp_pht_scheduler_upd_fifo.sv
// Synchronous update queue holding {index, taken} records; count, full and
// empty are all registered views.
module bp_pht_scheduler_upd_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;
    assign dout   = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/bp_pht_scheduler.sv
// Arbitrates the single-port PHT RAM between F-stage lookups and queued M-stage
// counter updates, after clearing the table with a post-reset sweep.
module bp_pht_scheduler
    import bp_pht_scheduler_pkg::*;
#(
    parameter int         IDX_W        = 6,
    parameter int         FIFO_DEPTH   = 4,
    parameter int         STARVE_LIMIT = 8,
    parameter logic [1:0] INIT_VAL     = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    bp_pht_scheduler_if.slave bus,
    output logic              init_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [IDX_W-1:0]  ram_addr,
    output logic [1:0]        ram_wdata,
    input  logic [1:0]        ram_rdata,
    output state_t            dbgState
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t           state;
    state_t           nextState;
    logic [IDX_W-1:0] sweepCtr;
    logic [SW-1:0]    starveCnt;
    logic             rspValid;
    logic             updDrop;
    logic             initDone;
    logic             lkReady;
    logic             updReady;
    logic             updChoice;
    logic             fifoPop;
    logic [IDX_W:0]   fifoHead;
    logic [CW-1:0]    fifoCount;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [IDX_W-1:0] headIdx;
    logic             headTaken;

    assign headIdx   = fifoHead[IDX_W:1];
    assign headTaken = fifoHead[0];
    assign updReady  = (fifoCount < CW'(FIFO_DEPTH)) & initDone;

    bp_pht_scheduler_upd_fifo #(
        .WIDTH (IDX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.upd_valid & updReady),
        .din   ({bus.upd_idx, bus.upd_taken}),
        .pop   (fifoPop),
        .dout  (fifoHead),
        .count (fifoCount),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    always_comb begin
        nextState = state;
        lkReady   = 1'b0;
        updChoice = 1'b0;
        fifoPop   = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            INIT: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = sweepCtr;
                ram_wdata = INIT_VAL;
                if (sweepCtr == '1) nextState = IDLE;
            end
            // The port carries the write-back, so no lookup can be granted here.
            UPD_RD: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = headIdx;
                ram_wdata = sat_next(ram_rdata, headTaken);
                fifoPop   = 1'b1;
                nextState = UPD_WR;
            end
            default: begin
                nextState = IDLE;
                if (!fifoEmpty && (!bus.lk_valid || fifoFull ||
                                   starveCnt == SW'(STARVE_LIMIT))) begin
                    updChoice = 1'b1;
                    ram_en    = 1'b1;
                    ram_addr  = headIdx;
                    nextState = UPD_RD;
                end else if (bus.lk_valid) begin
                    lkReady  = 1'b1;
                    ram_en   = 1'b1;
                    ram_addr = bus.lk_idx;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            sweepCtr  <= '0;
            starveCnt <= '0;
            rspValid  <= 1'b0;
            updDrop   <= 1'b0;
            initDone  <= 1'b0;
        end else begin
            state    <= nextState;
            rspValid <= lkReady;
            updDrop  <= bus.upd_valid & ~updReady;
            if (state == INIT) begin
                sweepCtr <= sweepCtr + IDX_W'(1);
                if (sweepCtr == '1) initDone <= 1'b1;
            end
            if (updChoice || fifoEmpty) begin
                starveCnt <= '0;
            end else if (lkReady && starveCnt != SW'(STARVE_LIMIT)) begin
                starveCnt <= starveCnt + SW'(1);
            end
        end
    end

    assign bus.lk_ready  = lkReady;
    assign bus.rsp_valid = rspValid;
    assign bus.rsp_taken = ram_rdata[1];
    assign bus.upd_ready = updReady;
    assign bus.upd_drop  = updDrop;
    assign init_done     = initDone;
    assign dbgState      = state;
endmodule

// File: tb/tb_bp_pht_scheduler.sv
// Self-checking bench for bp_pht_scheduler with a behavioural PHT RAM,
// a response scoreboard and directed corner-case sequences.
module tb_bp_pht_scheduler;
    import bp_pht_scheduler_pkg::*;

    localparam int IDX_W = 6;
    localparam int N     = 1 << IDX_W;

    logic             clk;
    logic             rst;
    logic             init_done;
    logic             ram_en;
    logic             ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [1:0]       ram_wdata;
    logic [1:0]       ram_rdata;
    state_t           dbgState;

    bp_pht_scheduler_if #(.IDX_W(IDX_W)) bus ();

    bp_pht_scheduler #(
        .IDX_W        (IDX_W),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8),
        .INIT_VAL     (2'b11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .dbgState  (dbgState)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- RAM model ----------------
    logic [1:0] ram [N];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata     <= ram[ram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int         asserts  = 0;
    int         failures = 0;
    logic [0:0] exp_q [$];
    logic [1:0] refCnt [N];
    logic       monEn     = 1'b0;
    logic       prevReady = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (monEn) begin
            check("rsp_valid_timing", {31'd0, bus.rsp_valid}, {31'd0, prevReady});
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rsp_taken", {31'd0, bus.rsp_taken}, {31'd0, exp_q.pop_front()});
                end
            end
            if (bus.lk_ready) exp_q.push_back(refCnt[bus.lk_idx][1]);
            prevReady = bus.lk_ready;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic resetRef();
        for (int i = 0; i < N; i++) refCnt[i] = 2'b11;
    endtask

    // Checks one full sweep; optionally pulses reset right after entry abortAt.
    task automatic sweepCheck(input int abortAt, input logic expLk);
        logic [14:0] exp;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            exp = {1'b1, 1'b1, 6'(i), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, (i == 11)};
            check($sformatf("sweep_%0d", i),
                  {17'd0, ram_en, ram_we, ram_addr, ram_wdata, bus.lk_ready,
                   bus.upd_ready, init_done, bus.rsp_valid, bus.upd_drop},
                  {17'd0, exp});
            if (i == 10) bus.upd_valid = 1'b1;
            if (i == 11) bus.upd_valid = 1'b0;
            if (i == abortAt) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                resetRef();
                return;
            end
        end
        @(negedge clk);
        check("init_done_rise", {30'd0, init_done, bus.lk_ready}, {30'd0, 1'b1, expLk});
    endtask

    task automatic doLookup(input logic [IDX_W-1:0] idx);
        @(posedge clk);
        #1;
        bus.lk_valid = 1'b1;
        bus.lk_idx   = idx;
        @(negedge clk);
        check("lookup_grant", {31'd0, bus.lk_ready}, 32'd1);
        @(posedge clk);
        #1 bus.lk_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic doUpdate(input logic [IDX_W-1:0] idx, input logic taken,
                            input logic [1:0] expCnt);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b1;
        bus.upd_idx   = idx;
        bus.upd_taken = taken;
        @(negedge clk);
        check("update_accept", {31'd0, bus.upd_ready}, 32'd1);
        @(posedge clk);
        #1 bus.upd_valid = 1'b0;
        repeat (5) @(posedge clk);
        refCnt[idx] = expCnt;
        check($sformatf("ram_after_upd_%0d", idx), {30'd0, ram[idx]}, {30'd0, expCnt});
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic             isUpd;
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic [1:0]       expCnt;
    } vec_t;

    vec_t vecs [20];
    int   grants;
    logic found;
    logic seenEn;

    initial begin
        vecs[0]  = '{1'b0, 6'd5,  1'b0, 2'b11};
        vecs[1]  = '{1'b1, 6'd5,  1'b0, 2'b01};
        vecs[2]  = '{1'b1, 6'd5,  1'b0, 2'b00};
        vecs[3]  = '{1'b0, 6'd5,  1'b0, 2'b00};
        vecs[4]  = '{1'b1, 6'd5,  1'b1, 2'b01};
        vecs[5]  = '{1'b0, 6'd5,  1'b0, 2'b01};
        vecs[6]  = '{1'b1, 6'd5,  1'b1, 2'b11};
        vecs[7]  = '{1'b1, 6'd5,  1'b1, 2'b10};
        vecs[8]  = '{1'b0, 6'd5,  1'b0, 2'b10};
        vecs[9]  = '{1'b1, 6'd5,  1'b1, 2'b10};
        vecs[10] = '{1'b1, 6'd5,  1'b0, 2'b11};
        vecs[11] = '{1'b1, 6'd5,  1'b0, 2'b01};
        vecs[12] = '{1'b0, 6'd5,  1'b0, 2'b01};
        vecs[13] = '{1'b1, 6'd5,  1'b0, 2'b00};
        vecs[14] = '{1'b1, 6'd5,  1'b0, 2'b00};
        vecs[15] = '{1'b0, 6'd5,  1'b0, 2'b00};
        vecs[16] = '{1'b0, 6'd0,  1'b0, 2'b11};
        vecs[17] = '{1'b0, 6'd63, 1'b0, 2'b11};
        vecs[18] = '{1'b1, 6'd63, 1'b1, 2'b10};
        vecs[19] = '{1'b0, 6'd63, 1'b0, 2'b10};

        rst           = 1'b1;
        bus.lk_valid  = 1'b0;
        bus.lk_idx    = '0;
        bus.upd_valid = 1'b0;
        bus.upd_idx   = '0;
        bus.upd_taken = 1'b0;
        resetRef();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {27'd0, bus.rsp_valid, bus.upd_drop, init_done,
                                bus.lk_ready, bus.upd_ready}, 32'd0);

        // Sweep with a lookup already pending; it is granted once init_done rises.
        bus.lk_valid = 1'b1;
        bus.lk_idx   = 6'd5;
        @(posedge clk);
        #1 rst = 1'b0;
        monEn = 1'b1;
        sweepCheck(-1, 1'b1);
        @(posedge clk);
        #1 bus.lk_valid = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 20; v++) begin
            if (vecs[v].isUpd) doUpdate(vecs[v].idx, vecs[v].taken, vecs[v].expCnt);
            else               doLookup(vecs[v].idx);
        end

        // Starvation: one queued update behind continuous lookups.
        @(posedge clk);
        #1;
        bus.lk_valid  = 1'b1;
        bus.lk_idx    = 6'd7;
        bus.upd_valid = 1'b1;
        bus.upd_idx   = 6'd9;
        bus.upd_taken = 1'b0;
        @(negedge clk);
        check("starve_push", {30'd0, bus.upd_ready, bus.lk_ready}, 32'd3);
        @(posedge clk);
        #1 bus.upd_valid = 1'b0;
        grants = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.lk_ready) grants++;
            else break;
        end
        check("starve_grants", grants, 8);
        check("starve_upd_read", {23'd0, bus.lk_ready, ram_en, ram_we, ram_addr},
              {23'd0, 1'b0, 1'b1, 1'b0, 6'd9});
        @(negedge clk);
        check("starve_upd_write", {21'd0, bus.lk_ready, ram_en, ram_we, ram_addr, ram_wdata},
              {21'd0, 1'b0, 1'b1, 1'b1, 6'd9, 2'b01});
        refCnt[9] = 2'b01;
        @(negedge clk);
        check("starve_resume", {31'd0, bus.lk_ready}, 32'd1);
        @(posedge clk);
        #1 bus.lk_valid = 1'b0;
        repeat (3) @(posedge clk);
        check("ram_9", {30'd0, ram[9]}, 32'd1);

        // Overflow: five back-to-back updates under continuous lookups.
        @(posedge clk);
        #1;
        bus.lk_valid = 1'b1;
        bus.lk_idx   = 6'd7;
        for (int k = 0; k < 5; k++) begin
            bus.upd_valid = 1'b1;
            bus.upd_idx   = 6'(10 + k);
            bus.upd_taken = 1'b1;
            @(negedge clk);
            if (k < 4) begin
                check($sformatf("fill_accept_%0d", k), {30'd0, bus.upd_ready, bus.lk_ready}, 32'd3);
            end else begin
                check("fill_full_priority",
                      {22'd0, bus.upd_ready, bus.lk_ready, ram_en, ram_we, ram_addr},
                      {22'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd10});
            end
            @(posedge clk);
            #1;
        end
        bus.upd_valid = 1'b0;
        @(negedge clk);
        check("drop_pulse", {22'd0, bus.upd_drop, ram_we, ram_addr, ram_wdata},
              {22'd0, 1'b1, 1'b1, 6'd10, 2'b10});
        refCnt[10] = 2'b10;
        @(posedge clk);
        #1 bus.lk_valid = 1'b0;
        repeat (20) @(posedge clk);
        for (int k = 10; k < 14; k++) begin
            refCnt[k] = 2'b10;
            check($sformatf("drain_ram_%0d", k), {30'd0, ram[k]}, 32'd2);
        end
        check("dropped_not_applied", {30'd0, ram[14]}, 32'd3);

        // Reset during an RMW, then again mid-sweep at entry 30.
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b1;
        bus.upd_idx   = 6'd20;
        bus.upd_taken = 1'b0;
        @(negedge clk);
        check("rmw_accept", {31'd0, bus.upd_ready}, 32'd1);
        @(posedge clk);
        #1 bus.upd_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ram_en && !ram_we && ram_addr == 6'd20) begin
                found = 1'b1;
                rst   = 1'b1;
                break;
            end
        end
        check("rmw_read_seen", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        resetRef();
        sweepCheck(30, 1'b0);
        sweepCheck(-1, 1'b0);
        seenEn = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ram_en) seenEn = 1'b1;
        end
        check("queue_cleared", {31'd0, seenEn}, 32'd0);
        check("ram_20_swept", {30'd0, ram[20]}, 32'd3);
        doLookup(6'd20);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
